// File: rtl/acia_rx_fifo_pkg.sv
// Shared definitions for the ACIA receive FIFO: the entry layout and the capture FSM states.
package acia_rx_fifo_pkg;

  localparam int ENT_W  = 10;
  localparam int ENT_FE = 8;
  localparam int ENT_PE = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAPT = 2'd1,
    ST_ACK  = 2'd2
  } cap_state_e;

  function automatic logic [ENT_W-1:0] pack_entry(input logic [7:0] data,
                                                  input logic       fe,
                                                  input logic       pe);
    return {pe, fe, data};
  endfunction

endpackage

// File: rtl/acia_rx_fifo_sync2.sv
// Two-flop synchroniser with async active-low reset; ACIA logic advances on falling PHI2.
module acia_rx_fifo_sync2 (
  input  logic clk,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(negedge clk or negedge rst_b) begin
    if (!rst_b) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/acia_rx_fifo.sv
// ACIA receive FIFO: captures bytes from the serial receiver handshake and queues them
// for the CPU register file with a show-ahead head entry and a level interrupt.
//
// state   | meaning
// IDLE    | waiting for synchronised RXFULL
// CAPT    | one cycle: store the byte (or drop it and flag overrun), raise RXTAKEN
// ACK     | hold RXTAKEN until the receiver releases RXFULL
module acia_rx_fifo
  import acia_rx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          PHI2,
  input  logic          RESET,
  input  logic          RXFULL,
  input  logic [7:0]    RXDATA,
  input  logic          FRAME,
  input  logic          PARITY,
  output logic          RXTAKEN,
  input  logic          RD_STB,
  input  logic          CLR_STB,
  input  logic          CLR_OVR,
  input  logic [AW:0]   THRESH,
  output logic [7:0]    DOUT,
  output logic          DFE,
  output logic          DPE,
  output logic          EMPTY,
  output logic          FULL,
  output logic [AW:0]   COUNT,
  output logic          OVERRUN,
  output logic          LVL_IRQ
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             overrun;
  logic             rxf_s;
  cap_state_e       state;
  logic             empty, full, pop, capt, wr_en, drop;
  logic [ENT_W-1:0] head;

  acia_rx_fifo_sync2 u_sync_rxf (
    .clk   (PHI2),
    .rst_b (RESET),
    .d     (RXFULL),
    .q     (rxf_s)
  );

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign pop   = RD_STB && !empty;
  assign capt  = (state == ST_CAPT);
  // A pop on the capture edge frees the slot, so a full FIFO can still accept.
  assign wr_en = capt && (!full || pop);
  assign drop  = capt && !wr_en;

  always_ff @(negedge PHI2 or negedge RESET) begin
    if (!RESET) begin
      state   <= ST_IDLE;
      RXTAKEN <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (rxf_s) state <= ST_CAPT;
        ST_CAPT: begin
          RXTAKEN <= 1'b1;
          state   <= ST_ACK;
        end
        ST_ACK: if (!rxf_s) begin
          RXTAKEN <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          RXTAKEN <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(negedge PHI2 or negedge RESET) begin
    if (!RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else if (CLR_STB) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (!wr_en && pop) count <= count - 1'b1;
      if (drop)         overrun <= 1'b1;
      else if (CLR_OVR) overrun <= 1'b0;
    end
  end

  always_ff @(negedge PHI2) begin
    if (wr_en && !CLR_STB) mem[wr_ptr] <= pack_entry(RXDATA, FRAME, PARITY);
  end

  assign head    = mem[rd_ptr];
  assign DOUT    = empty ? 8'h00 : head[7:0];
  assign DFE     = !empty && head[ENT_FE];
  assign DPE     = !empty && head[ENT_PE];
  assign EMPTY   = empty;
  assign FULL    = full;
  assign COUNT   = count;
  assign OVERRUN = overrun;
  assign LVL_IRQ = (THRESH != '0) && (count >= THRESH);

endmodule
